// File: rtl/bsg_manycore_host_pkg.sv
// Shared types and defaults for the manycore host request arbiter.
package bsg_manycore_host_pkg;

  localparam int unsigned host_num_req_default = 2;
  localparam int unsigned host_max_out_default = 16;

  // Tag width that stays at least one bit for a single requester.
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold the value n itself.
  function automatic int unsigned width_of(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned host_tag_width_default = safe_clog2(host_num_req_default);

  typedef logic [host_tag_width_default-1:0] host_tag_t;

endpackage

// File: rtl/bsg_manycore_host_out_counter.sv
// Per-requester outstanding-request counter: saturating up/down with underflow flag.
module bsg_manycore_host_out_counter
  import bsg_manycore_host_pkg::*;
#(
  parameter  int unsigned max_out_p      = host_max_out_default,
  localparam int unsigned count_width_lp = width_of(max_out_p)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      up,
  input  logic                      down,
  output logic [count_width_lp-1:0] count,
  output logic                      underflow_c
);

  logic [count_width_lp-1:0] count_r;
  logic [count_width_lp-1:0] count_n;

  // Simultaneous up and down leaves the count unchanged; a down at zero is flagged.
  always_comb begin
    count_n     = count_r;
    underflow_c = down && (count_r == '0);
    if (up && !down && (count_r != count_width_lp'(max_out_p))) begin
      count_n = count_r + count_width_lp'(1);
    end else if (down && !up && (count_r != '0)) begin
      count_n = count_r - count_width_lp'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_r <= '0;
    else       count_r <= count_n;
  end

  assign count = count_r;

endmodule

// File: rtl/bsg_manycore_host_req_arbiter.sv
// Round-robin arbiter sharing the host I/O endpoint, with tag-based response steering.
// Optional fence ports are enabled by defining BSG_MANYCORE_HOST_ARB_FENCE_EN.
module bsg_manycore_host_req_arbiter
  import bsg_manycore_host_pkg::*;
#(
  parameter  int unsigned num_req_p             = host_num_req_default,
  parameter  int unsigned packet_width_p        = 32,
  parameter  int unsigned return_packet_width_p = 32,
  parameter  int unsigned max_out_p             = host_max_out_default,
  localparam int unsigned tag_width_lp          = safe_clog2(num_req_p),
  localparam int unsigned count_width_lp        = width_of(max_out_p)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [num_req_p-1:0]                  req_v_i,
  input  logic [num_req_p*packet_width_p-1:0]   req_data_i,
  input  logic [num_req_p-1:0]                  req_expect_resp_i,
  output logic [num_req_p-1:0]                  req_ready_o,
  output logic                                  out_v_o,
  output logic [packet_width_p-1:0]             out_data_o,
  output logic [tag_width_lp-1:0]               out_tag_o,
  input  logic                                  out_ready_i,
  input  logic                                  resp_v_i,
  input  logic [return_packet_width_p-1:0]      resp_data_i,
  input  logic [tag_width_lp-1:0]               resp_tag_i,
  output logic                                  resp_ready_o,
  output logic [num_req_p-1:0]                  resp_v_o,
  output logic [return_packet_width_p-1:0]      resp_data_o,
  input  logic [num_req_p-1:0]                  resp_ready_i,
  output logic [num_req_p*count_width_lp-1:0]   out_count_o,
`ifdef BSG_MANYCORE_HOST_ARB_FENCE_EN
  input  logic [num_req_p-1:0]                  fence_i,
  output logic [num_req_p-1:0]                  fence_done_o,
`endif
  output logic                                  error_o
);

  localparam int unsigned tag_ext_lp = tag_width_lp + 1;

  logic [num_req_p-1:0][packet_width_p-1:0] req_data;
  logic [num_req_p-1:0][count_width_lp-1:0] count;
  logic [num_req_p-1:0]                     fenced;
  logic [num_req_p-1:0]                     eligible;
  logic [num_req_p-1:0]                     up;
  logic [num_req_p-1:0]                     down;
  logic [num_req_p-1:0]                     underflow;
  logic [tag_width_lp-1:0]                  rr_ptr_r;
  logic [tag_width_lp-1:0]                  grant;
  logic [tag_width_lp-1:0]                  idx;
  logic                                     any_eligible;
  logic                                     req_hs;
  logic                                     resp_hs;
  logic                                     tag_oob;
  logic                                     resp_sel_ready;
  logic                                     error_r;

  assign req_data = req_data_i;

`ifdef BSG_MANYCORE_HOST_ARB_FENCE_EN
  assign fenced = fence_i;
`else
  assign fenced = '0;
`endif

  // A requester expecting a response needs a free credit to compete.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      eligible[i] = !reset_i && req_v_i[i] && !fenced[i]
                  && (!req_expect_resp_i[i] || (count[i] < count_width_lp'(max_out_p)));
    end
  end

  // First eligible index at or after rr_ptr, wrapping around.
  always_comb begin
    grant        = rr_ptr_r;
    any_eligible = 1'b0;
    idx          = rr_ptr_r;
    for (int unsigned k = 0; k < num_req_p; k++) begin
      if (!any_eligible && eligible[idx]) begin
        any_eligible = 1'b1;
        grant        = idx;
      end
      idx = (idx == tag_width_lp'(num_req_p - 1)) ? '0 : idx + tag_width_lp'(1);
    end
  end

  assign out_v_o    = any_eligible;
  assign out_data_o = req_data[grant];
  assign out_tag_o  = grant;
  assign req_hs     = any_eligible && out_ready_i;

  // Tags beyond the requester range are swallowed so the endpoint never stalls on them.
  assign tag_oob = {1'b0, resp_tag_i} >= tag_ext_lp'(num_req_p);

  always_comb begin
    req_ready_o    = '0;
    resp_v_o       = '0;
    up             = '0;
    down           = '0;
    resp_sel_ready = 1'b0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      req_ready_o[i] = req_hs && (grant == tag_width_lp'(i));
      up[i]          = req_ready_o[i] && req_expect_resp_i[i];
      if (resp_tag_i == tag_width_lp'(i)) begin
        resp_v_o[i]    = !reset_i && resp_v_i;
        resp_sel_ready = resp_ready_i[i];
      end
    end
    resp_ready_o = !reset_i && (tag_oob || resp_sel_ready);
    resp_hs      = resp_v_i && resp_ready_o;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      down[i] = resp_hs && !tag_oob && (resp_tag_i == tag_width_lp'(i));
    end
  end

  assign resp_data_o = resp_data_i;

  for (genvar i = 0; i < num_req_p; i++) begin : g_cnt
    bsg_manycore_host_out_counter #(.max_out_p(max_out_p)) u_cnt (
      .clk         (clk_i),
      .reset       (reset_i),
      .up          (up[i]),
      .down        (down[i]),
      .count       (count[i]),
      .underflow_c (underflow[i])
    );
  end

  assign out_count_o = count;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_r <= '0;
    end else if (req_hs) begin
      rr_ptr_r <= (grant == tag_width_lp'(num_req_p - 1)) ? '0 : grant + tag_width_lp'(1);
    end
  end

  // Sticky until reset: unmatched response or out-of-range tag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      error_r <= 1'b0;
    end else if ((|underflow) || (resp_v_i && tag_oob)) begin
      error_r <= 1'b1;
    end
  end

  assign error_o = error_r;

`ifdef BSG_MANYCORE_HOST_ARB_FENCE_EN
  logic [num_req_p-1:0] fence_done_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fence_done_r <= '0;
    end else begin
      for (int unsigned i = 0; i < num_req_p; i++) begin
        fence_done_r[i] <= fence_i[i] && (count[i] == '0);
      end
    end
  end

  assign fence_done_o = fence_done_r;
`endif

endmodule
